// File: rtl/display_scan.sv
// Time-multiplexed seven-segment scan controller with a frame-boundary shadow register.
// Optional leading-zero blanking of the displayed frame is enabled by defining SCAN_LZB_EN.
module display_scan #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic                  ready,
  output logic [3:0]            data,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] active;
  logic [DIGITS-1:0][3:0] shadow;
  logic [DIGITS-1:0][3:0] shown;
  logic                   pending;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic                   state;
  logic [DIGITS-1:0]      sel_onehot;
  logic                   accept;
  logic                   boundary;
  logic                   commit;

  // ready is always the complement of pending, so accept and commit never coincide.
  assign accept     = load & ready;
  assign boundary   = scan_en & (state == ST_SHOW) & (cnt == SHOW_LAST) & (idx == IDX_LAST);
  assign commit     = pending & (boundary | ~scan_en);
  assign sel_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

`ifdef SCAN_LZB_EN
  logic lead_zero;

  // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    shown     = active;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead_zero && (active[i] == 4'h0)) shown[i] = 4'hF;
      else                                  lead_zero = 1'b0;
    end
  end
`else
  assign shown = active;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the frame registers are reset explicitly so the display is blank, not random, after reset.
      active     <= '1;
      shadow     <= '1;
      pending    <= 1'b0;
      ready      <= 1'b1;
      idx        <= '0;
      cnt        <= '0;
      state      <= ST_BLANK;
      digit_sel  <= '0;
      data       <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        shadow  <= wr_data;
        pending <= 1'b1;
        ready   <= 1'b0;
      end else if (commit) begin
        active  <= shadow;
        pending <= 1'b0;
        ready   <= 1'b1;
      end

      if (!scan_en) begin
        state     <= ST_BLANK;
        idx       <= '0;
        cnt       <= '0;
        digit_sel <= '0;
        data      <= 4'hF;
      end else if (state == ST_BLANK) begin
        if (cnt == BLANK_LAST) begin
          state     <= ST_SHOW;
          cnt       <= '0;
          digit_sel <= sel_onehot;
          data      <= shown[idx];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == SHOW_LAST) begin
          state      <= ST_BLANK;
          cnt        <= '0;
          digit_sel  <= '0;
          data       <= 4'hF;
          idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          frame_done <= boundary;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed testbench for display_scan with DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 (40-cycle frame).
// Expected leading-zero-blanking results follow SCAN_LZB_EN when it is defined for the build.
module tb_display_scan;

  localparam int DIGITS       = 4;
  localparam int PRESCALE     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT         = PRESCALE + BLANK_CYCLES;
  localparam int FRAME        = DIGITS * SLOT;

`ifdef SCAN_LZB_EN
  localparam logic [15:0] EXP_0050 = 16'hFF50;
  localparam logic [15:0] EXP_0000 = 16'hFFF0;
`else
  localparam logic [15:0] EXP_0050 = 16'h0050;
  localparam logic [15:0] EXP_0000 = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic        load;
  logic [15:0] wr_data;
  logic        ready;
  logic [3:0]  data;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  display_scan #(
    .DIGITS      (DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .load      (load),
    .wr_data   (wr_data),
    .ready     (ready),
    .data      (data),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle load strobe presented at a negedge, consumed by the following posedge.
  task automatic do_load(input logic [15:0] value);
    load    = 1'b1;
    wr_data = value;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_frame_start();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", 16'(frame_done), 16'h1);
  endtask

  // Called at the first cycle of a frame; checks one whole frame cycle by cycle.
  task automatic check_frame(input string name, input logic [15:0] exp);
    int          slot;
    int          pos;
    logic [3:0]  exp_sel;
    logic [3:0]  exp_data;
    for (int k = 0; k < FRAME; k++) begin
      slot = k / SLOT;
      pos  = k % SLOT;
      if (pos < BLANK_CYCLES) begin
        exp_sel  = 4'b0000;
        exp_data = 4'hF;
      end else begin
        exp_sel  = 4'b0001 << slot;
        exp_data = exp[slot*4 +: 4];
      end
      check($sformatf("%s sel k=%0d", name, k), 16'(digit_sel), 16'(exp_sel));
      check($sformatf("%s data k=%0d", name, k), 16'(data), 16'(exp_data));
      if (k != 0) check($sformatf("%s fd k=%0d", name, k), 16'(frame_done), 16'h0);
      @(negedge clk);
    end
    check($sformatf("%s fd boundary", name), 16'(frame_done), 16'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    scan_en = 1'b1;
    load    = 1'b0;
    wr_data = 16'h0;
    skip(3);

    // Reset/idle: blank frame, frame_done every 40 cycles.
    rst_n = 1'b1;
    check("rst ready", 16'(ready), 16'h1);
    check("rst sel", 16'(digit_sel), 16'h0);
    check("rst data", 16'(data), 16'hF);
    check_frame("idle", 16'hFFFF);

    // Load mid-frame, then an ignored load while ready=0.
    skip(15);
    do_load(16'h1234);
    check("load ready low", 16'(ready), 16'h0);
    skip(4);
    do_load(16'hABCD);
    check("ignored ready low", 16'(ready), 16'h0);
    wait_frame_start();
    check("commit ready high", 16'(ready), 16'h1);
    check_frame("f1234", 16'h1234);

    // Load on the boundary edge: commits one frame later.
    skip(FRAME - 1);
    do_load(16'h5678);
    check("bnd ready low", 16'(ready), 16'h0);
    check("bnd fd", 16'(frame_done), 16'h1);
    check_frame("bnd old", 16'h1234);
    check("bnd ready high", 16'(ready), 16'h1);
    check_frame("f5678", 16'h5678);

    // Disable during digit 2 SHOW with a pending frame.
    skip(3);
    do_load(16'h9ABC);
    check("dis ready low", 16'(ready), 16'h0);
    skip(20);
    check("dis pre sel", 16'(digit_sel), 16'h4);
    check("dis pre data", 16'(data), 16'h6);
    scan_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("dis sel %0d", i), 16'(digit_sel), 16'h0);
      check($sformatf("dis data %0d", i), 16'(data), 16'hF);
      check($sformatf("dis ready %0d", i), 16'(ready), 16'h1);
      check($sformatf("dis fd %0d", i), 16'(frame_done), 16'h0);
    end
    scan_en = 1'b1;
    check_frame("f9ABC", 16'h9ABC);

    // Asynchronous reset between edges in the middle of a SHOW phase.
    skip(5);
    do_load(16'hDEF0);
    check("ar ready low", 16'(ready), 16'h0);
    skip(8);
    check("ar pre sel", 16'(digit_sel), 16'h2);
    #2 rst_n = 1'b0;
    #1;
    check("ar sel", 16'(digit_sel), 16'h0);
    check("ar data", 16'(data), 16'hF);
    check("ar ready", 16'(ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("post rst", 16'hFFFF);

    // Leading-zero blanking (or verbatim display without it).
    skip(5);
    do_load(16'h0050);
    wait_frame_start();
    check_frame("f0050", EXP_0050);
    skip(5);
    do_load(16'h0000);
    wait_frame_start();
    check_frame("f0000", EXP_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
